// File: rtl/rvvi_tx_fifo.sv
// rvvi_tx_fifo: word FIFO from the RVVI AXI write stream to a byte-wide MAC transmit port.
// Whole frames are released, or cut through when the buffer fills; define
// RVVI_TX_MIN_FRAME_PAD_EN to zero-pad frames shorter than 60 bytes.
module rvvi_tx_fifo #(
  parameter int unsigned DEPTH_WORDS = 512
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [31:0]                    RvviAxiWdata,
  input  logic [3:0]                     RvviAxiWstrb,
  input  logic                           RvviAxiWlast,
  input  logic                           RvviAxiWvalid,
  output logic                           RvviAxiWready,
  output logic [7:0]                     TxData,
  output logic                           TxValid,
  output logic                           TxLast,
  input  logic                           TxReady,
  output logic [$clog2(DEPTH_WORDS):0]   FramesStored,
  output logic                           Overflow
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned EW = 35;

`ifdef RVVI_TX_MIN_FRAME_PAD_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_PAD} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_e;
`endif

  state_e        state_q, state_d;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]   frames_q, frames_d;
  logic          ovf_q, ovf_d;
  logic          wr_open_q;
  logic          word_vld_q, word_vld_d;
  logic [1:0]    byte_q, byte_d;
  logic [EW-1:0] mem [DEPTH_WORDS];
  logic [EW-1:0] word_q;
  logic [1:0]    wr_cnt;
  logic          full, empty, wr_en, rd_en;
  logic [31:0]   w_data;
  logic [1:0]    w_cnt;
  logic          w_last, word_end;
  logic [7:0]    cur_byte;
  logic          frame_in, frame_out;
`ifdef RVVI_TX_MIN_FRAME_PAD_EN
  logic [5:0]    sent_q, sent_d;
`endif

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Wready is held low through reset and rises on the first edge after release
  assign RvviAxiWready = wr_open_q & ~full;
  assign wr_en         = RvviAxiWvalid & RvviAxiWready;

  // Entries carry (byte count - 1); only last words may be short
  always_comb begin
    wr_cnt = 2'd3;
    if (RvviAxiWlast) begin
      case (RvviAxiWstrb)
        4'h1:    wr_cnt = 2'd0;
        4'h3:    wr_cnt = 2'd1;
        4'h7:    wr_cnt = 2'd2;
        default: wr_cnt = 2'd3;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {RvviAxiWlast, wr_cnt, RvviAxiWdata};
    if (rd_en) word_q <= mem[rd_ptr_q[AW-1:0]];
  end

  assign w_data   = word_q[31:0];
  assign w_cnt    = word_q[33:32];
  assign w_last   = word_q[34];
  assign word_end = (byte_q == w_cnt);

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = w_data[7:0];
      2'd1:    cur_byte = w_data[15:8];
      2'd2:    cur_byte = w_data[23:16];
      default: cur_byte = w_data[31:24];
    endcase
  end

  // The next word is fetched on the handshake of a word's final byte so it is
  // ready the following cycle; an empty buffer (cut-through) stalls TxValid instead.
  always_comb begin
    state_d    = state_q;
    word_vld_d = word_vld_q;
    byte_d     = byte_q;
    ovf_d      = ovf_q;
    rd_en      = 1'b0;
    TxValid    = 1'b0;
    TxData     = '0;
    TxLast     = 1'b0;
`ifdef RVVI_TX_MIN_FRAME_PAD_EN
    sent_d     = sent_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef RVVI_TX_MIN_FRAME_PAD_EN
        sent_d = '0;
`endif
        if (frames_q != '0) begin
          state_d = S_FETCH;
        end else if (full) begin
          state_d = S_FETCH;
          ovf_d   = 1'b1;
        end
      end
      S_FETCH: begin
        rd_en = ~empty;
        if (!empty) begin
          word_vld_d = 1'b1;
          byte_d     = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (word_vld_q) begin
          TxValid = 1'b1;
          TxData  = cur_byte;
`ifdef RVVI_TX_MIN_FRAME_PAD_EN
          TxLast  = w_last & word_end & (sent_q >= 6'd59);
`else
          TxLast  = w_last & word_end;
`endif
          if (TxReady) begin
`ifdef RVVI_TX_MIN_FRAME_PAD_EN
            if (sent_q != 6'd63) sent_d = sent_q + 6'd1;
`endif
            if (!word_end) begin
              byte_d = byte_q + 2'd1;
            end else if (w_last) begin
              word_vld_d = 1'b0;
`ifdef RVVI_TX_MIN_FRAME_PAD_EN
              state_d    = TxLast ? S_IDLE : S_PAD;
`else
              state_d    = S_IDLE;
`endif
            end else begin
              rd_en      = ~empty;
              word_vld_d = ~empty;
              byte_d     = '0;
            end
          end
        end else begin
          rd_en      = ~empty;
          word_vld_d = ~empty;
          byte_d     = '0;
        end
      end
`ifdef RVVI_TX_MIN_FRAME_PAD_EN
      S_PAD: begin
        TxValid = 1'b1;
        TxLast  = (sent_q == 6'd59);
        if (TxReady) begin
          sent_d = sent_q + 6'd1;
          if (TxLast) state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign frame_in  = wr_en & RvviAxiWlast;
  assign frame_out = TxValid & TxReady & TxLast;

  always_comb begin
    case ({frame_in, frame_out})
      2'b10:   frames_d = frames_q + (AW+1)'(1);
      2'b01:   frames_d = frames_q - (AW+1)'(1);
      default: frames_d = frames_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      frames_q   <= '0;
      ovf_q      <= 1'b0;
      wr_open_q  <= 1'b0;
      word_vld_q <= 1'b0;
      byte_q     <= '0;
`ifdef RVVI_TX_MIN_FRAME_PAD_EN
      sent_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_q + (AW+1)'(wr_en);
      rd_ptr_q   <= rd_ptr_q + (AW+1)'(rd_en);
      frames_q   <= frames_d;
      ovf_q      <= ovf_d;
      wr_open_q  <= 1'b1;
      word_vld_q <= word_vld_d;
      byte_q     <= byte_d;
`ifdef RVVI_TX_MIN_FRAME_PAD_EN
      sent_q     <= sent_d;
`endif
    end
  end

  assign FramesStored = frames_q;
  assign Overflow     = ovf_q;

endmodule

// File: tb/tb_rvvi_tx_fifo.sv
// tb_rvvi_tx_fifo: directed table of single frames plus hand sequences for stall,
// same-cycle commit/retire, cut-through overflow and mid-frame reset.
module tb_rvvi_tx_fifo;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] RvviAxiWdata = '0;
  logic [3:0]  RvviAxiWstrb = '0;
  logic        RvviAxiWlast = 1'b0;
  logic        RvviAxiWvalid = 1'b0;
  logic        RvviAxiWready;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxLast;
  logic        TxReady = 1'b0;
  logic [9:0]  FramesStored;
  logic        Overflow;

  rvvi_tx_fifo #(.DEPTH_WORDS(512)) dut (
    .clk(clk), .resetn(resetn),
    .RvviAxiWdata(RvviAxiWdata), .RvviAxiWstrb(RvviAxiWstrb),
    .RvviAxiWlast(RvviAxiWlast), .RvviAxiWvalid(RvviAxiWvalid),
    .RvviAxiWready(RvviAxiWready),
    .TxData(TxData), .TxValid(TxValid), .TxLast(TxLast), .TxReady(TxReady),
    .FramesStored(FramesStored), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int acc_cyc = 0;
  int last_acc = 0;
  int wait_total = 0;
  int hold_err = 0;

  logic [7:0] rx_data[$];
  logic       rx_last[$];
  int         rx_cyc[$];

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  // Byte capture and stall-hold monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (TxValid && TxReady) begin
      rx_data.push_back(TxData);
      rx_last.push_back(TxLast);
      rx_cyc.push_back(cyc);
    end
    if (resetn && prev_stall && !(TxValid && TxData == prev_data && TxLast == prev_last))
      hold_err++;
    prev_stall = resetn && TxValid && !TxReady;
    prev_data  = TxData;
    prev_last  = TxLast;
  end

  typedef struct {
    int         nwords;
    logic [3:0] last_strb;
    logic [7:0] seed;
    int         exp_len;
    int         exp_len_pad;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_word(input logic [7:0] s, input int i);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = s + 8'(4*i + j);
    return w;
  endfunction

  function automatic int pad_len(input int n);
`ifdef RVVI_TX_MIN_FRAME_PAD_EN
    return (n < 60) ? 60 : n;
`else
    return n;
`endif
  endfunction

  task automatic clear_rx();
    rx_data.delete();
    rx_last.delete();
    rx_cyc.delete();
  endtask

  // Starts and ends just after a rising edge; the word is accepted on the edge it returns at
  task automatic send_word(input logic [31:0] d, input logic [3:0] s, input logic l);
    int g = 0;
    RvviAxiWdata  = d;
    RvviAxiWstrb  = s;
    RvviAxiWlast  = l;
    RvviAxiWvalid = 1'b1;
    @(negedge clk);
    while (!RvviAxiWready && g < 3000) begin
      step();
      @(negedge clk);
      g++;
    end
    wait_total += g;
    if (!RvviAxiWready) fail_now("wr_accept");
    acc_cyc = cyc;
    step();
    RvviAxiWvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] seed, input int n, input logic [3:0] strb);
    for (int i = 0; i < n; i++)
      send_word(mk_word(seed, i), (i == n - 1) ? strb : 4'hF, i == n - 1);
    last_acc = acc_cyc;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int g = 0;
    while (rx_data.size() < n && g < budget) begin
      step();
      g++;
    end
    if (rx_data.size() < n) fail_now("rx_bytes");
  endtask

  task automatic wait_valid();
    int g = 0;
    @(negedge clk);
    while (!TxValid && g < 50) begin
      step();
      @(negedge clk);
      g++;
    end
    if (!TxValid) fail_now("tx_valid");
    step();
  endtask

  task automatic check_frame(input string tag, input int off, input logic [7:0] seed,
                             input int ndata, input int elen);
    int bad = 0;
    int nlast = 0;
    int lastk = -1;
    logic [7:0] e;
    for (int k = 0; k < elen; k++) begin
      if (off + k >= rx_data.size()) begin
        bad++;
      end else begin
        e = (k < ndata) ? seed + 8'(k) : 8'h00;
        if (rx_data[off + k] !== e) bad++;
        if (rx_last[off + k]) begin
          nlast++;
          lastk = k;
        end
      end
    end
    chk({tag, "_data"}, bad, 0);
    chk({tag, "_lastpos"}, lastk, elen - 1);
    chk({tag, "_lastcnt"}, nlast, 1);
  endtask

  initial begin
    int n, elen, a_len, b_len;
    vecs[0] = '{16, 4'hF, 8'h00, 64, 64};
    vecs[1] = '{3,  4'h3, 8'h40, 10, 60};
    vecs[2] = '{1,  4'h1, 8'hA0, 1,  60};
    vecs[3] = '{2,  4'h7, 8'h10, 7,  60};
    vecs[4] = '{15, 4'hF, 8'h80, 60, 60};
    vecs[5] = '{15, 4'h7, 8'hC0, 59, 60};

    // Reset state
    #2 resetn = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_txvalid", TxValid, 0);
    chk("rst_txlast", TxLast, 0);
    chk("rst_txdata", TxData, 0);
    chk("rst_wready", RvviAxiWready, 0);
    chk("rst_frames", FramesStored, 0);
    chk("rst_ovf", Overflow, 0);
    step();
    resetn = 1'b1;
    @(negedge clk);
    chk("rel_wready_low", RvviAxiWready, 0);
    step();
    @(negedge clk);
    chk("rel_wready_high", RvviAxiWready, 1);
    step();

    // Single frames, TxReady held high
    TxReady = 1'b1;
    for (int v = 0; v < 6; v++) begin
      clear_rx();
`ifdef RVVI_TX_MIN_FRAME_PAD_EN
      elen = vecs[v].exp_len_pad;
`else
      elen = vecs[v].exp_len;
`endif
      send_frame(vecs[v].seed, vecs[v].nwords, vecs[v].last_strb);
      wait_bytes(elen, 400);
      repeat (5) step();
      n = rx_data.size();
      chk($sformatf("v%0d_len", v), n, elen);
      check_frame($sformatf("v%0d", v), 0, vecs[v].seed, vecs[v].exp_len, elen);
      chk($sformatf("v%0d_latency", v), (n > 0) ? rx_cyc[0] - last_acc : -1, 3);
      chk($sformatf("v%0d_gapless", v), (n > 0) ? rx_cyc[n-1] - rx_cyc[0] : -1, n - 1);
      chk($sformatf("v%0d_frames", v), FramesStored, 0);
    end
    chk("ovf_quiet", Overflow, 0);

    // Two frames buffered under back-pressure, then drained
    clear_rx();
    TxReady = 1'b0;
    a_len = pad_len(8);
    b_len = pad_len(3);
    send_frame(8'h20, 2, 4'hF);
    send_frame(8'h60, 1, 4'h7);
    repeat (6) step();
    @(negedge clk);
    chk("s3_frames2", FramesStored, 2);
    chk("s3_valid", TxValid, 1);
    chk("s3_data_a", TxData, 8'h20);
    repeat (5) step();
    @(negedge clk);
    chk("s3_data_b", TxData, 8'h20);
    chk("s3_no_hs", rx_data.size(), 0);
    step();
    TxReady = 1'b1;
    wait_bytes(a_len + b_len, 400);
    repeat (5) step();
    chk("s3_len", rx_data.size(), a_len + b_len);
    check_frame("s3a", 0, 8'h20, 8, a_len);
    check_frame("s3b", a_len, 8'h60, 3, b_len);
    chk("s3_b2b_gap_ok", (rx_data.size() > a_len) ? int'(rx_cyc[a_len] - rx_cyc[a_len-1] <= 3) : 0, 1);
    chk("s3_frames0", FramesStored, 0);

    // Last word accepted on the same edge as the previous frame's TxLast handshake
    clear_rx();
    TxReady = 1'b0;
    a_len = pad_len(4);
    b_len = pad_len(1);
    send_frame(8'h30, 1, 4'hF);
    wait_valid();
    TxReady = 1'b1;
    repeat (a_len - 1) step();
    RvviAxiWdata  = mk_word(8'h70, 0);
    RvviAxiWstrb  = 4'h1;
    RvviAxiWlast  = 1'b1;
    RvviAxiWvalid = 1'b1;
    @(negedge clk);
    chk("s5_txlast_hs", TxValid & TxLast, 1);
    chk("s5_wready", RvviAxiWready, 1);
    chk("s5_frames_pre", FramesStored, 1);
    step();
    RvviAxiWvalid = 1'b0;
    @(negedge clk);
    chk("s5_frames_same", FramesStored, 1);
    step();
    wait_bytes(a_len + b_len, 400);
    repeat (5) step();
    chk("s5_len", rx_data.size(), a_len + b_len);
    check_frame("s5a", 0, 8'h30, 4, a_len);
    check_frame("s5b", a_len, 8'h70, 1, b_len);
    chk("s5_frames0", FramesStored, 0);

    // 600-word frame into 512 words: fill, overflow, cut-through
    clear_rx();
    TxReady = 1'b1;
    wait_total = 0;
    for (int i = 0; i < 512; i++) send_word(mk_word(8'h05, i), 4'hF, 1'b0);
    chk("s4_fill_nostall", wait_total, 0);
    @(negedge clk);
    chk("s4_full_wready", RvviAxiWready, 0);
    chk("s4_frames0_full", FramesStored, 0);
    step();
    @(negedge clk);
    chk("s4_ovf", Overflow, 1);
    step();
    for (int i = 512; i < 600; i++) send_word(mk_word(8'h05, i), 4'hF, i == 599);
    wait_bytes(2400, 4000);
    repeat (5) step();
    chk("s4_len", rx_data.size(), pad_len(2400));
    check_frame("s4", 0, 8'h05, 2400, pad_len(2400));
    chk("s4_ovf_sticky", Overflow, 1);
    chk("s4_frames0", FramesStored, 0);

    // Reset in the middle of a frame, with a partial frame also buffered
    clear_rx();
    TxReady = 1'b0;
    send_frame(8'h50, 4, 4'hF);
    send_word(mk_word(8'hE0, 0), 4'hF, 1'b0);
    send_word(mk_word(8'hE0, 1), 4'hF, 1'b0);
    wait_valid();
    TxReady = 1'b1;
    repeat (3) step();
    resetn = 1'b0;
    #1;
    chk("s6_txvalid", TxValid, 0);
    chk("s6_txlast", TxLast, 0);
    chk("s6_txdata", TxData, 0);
    chk("s6_wready", RvviAxiWready, 0);
    chk("s6_frames", FramesStored, 0);
    chk("s6_ovf_clr", Overflow, 0);
    step();
    step();
    resetn = 1'b1;
    clear_rx();
    repeat (20) step();
    chk("s6_no_stale", rx_data.size(), 0);
    chk("s6_frames_after", FramesStored, 0);
    send_frame(8'h99, 1, 4'h1);
    wait_bytes(pad_len(1), 200);
    repeat (5) step();
    chk("s6_fresh_len", rx_data.size(), pad_len(1));
    check_frame("s6_fresh", 0, 8'h99, 1, pad_len(1));

    chk("hold_stable", hold_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/rvvi_tx_fifo.md
RVVI_TX_FIFO -- requirements
Module: rvvi_tx_fifo

Interface
REQ-001 Parameter DEPTH_WORDS, default 512, meaning word-buffer capacity; SHALL be a power of two and at least 16.
REQ-002 Port clk, input, 1, meaning the single clock; all state SHALL be clocked on its rising edge.
REQ-003 Port resetn, input, 1, meaning asynchronous active-low reset.
REQ-004 Port RvviAxiWdata, input, 32, meaning write data word; byte 0 is [7:0].
REQ-005 Port RvviAxiWstrb, input, 4, meaning byte enables.
REQ-006 Port RvviAxiWlast, input, 1, meaning final word of frame.
REQ-007 Port RvviAxiWvalid, input, 1, meaning the word is valid.
REQ-008 Port RvviAxiWready, output, 1, meaning the word is accepted this cycle when high with Wvalid.
REQ-009 Port TxData, output, 8, meaning MAC transmit byte.
REQ-010 Port TxValid, output, 1, meaning TxData is valid.
REQ-011 Port TxLast, output, 1, meaning final byte of frame.
REQ-012 Port TxReady, input, 1, meaning the MAC accepts the byte this cycle.
REQ-013 Port FramesStored, output, $clog2(DEPTH_WORDS)+1, meaning count of complete frames buffered.
REQ-014 Port Overflow, output, 1, meaning sticky cut-through event flag.

Function
REQ-015 Each entry SHALL store the word, a valid-byte count (1-4) and the last flag; a word is written iff Wvalid&Wready.
REQ-016 Non-last words SHALL be 4'hF; last words SHALL be 4'h1, 4'h3, 4'h7 or 4'hF, and only low-order enabled bytes are sent.
REQ-017 Wready SHALL be low when the buffer holds DEPTH_WORDS words, and high otherwise.
REQ-018 FramesStored SHALL increment on acceptance of a last word and decrement on the TxValid&TxReady&TxLast handshake; it SHALL not change when both occur in the same cycle.
REQ-019 Output FSM states: IDLE, FETCH, SEND, and PAD (PAD only with the macro).
REQ-020 IDLE->FETCH when FramesStored>0, or when the buffer is full with FramesStored==0 (cut-through); the cut-through case SHALL set Overflow.
REQ-021 FETCH SHALL issue the synchronous buffer read, then go to SEND.
REQ-022 From IDLE, TxValid SHALL first assert exactly 3 cycles after the cycle in which the committing last word is accepted.
REQ-023 SEND SHALL emit bytes in order [7:0], [15:8], [23:16], [31:24]; TxData/TxValid/TxLast SHALL hold while TxValid&~TxReady.
REQ-024 With TxReady held high, bytes within a frame SHALL be emitted on consecutive cycles with no gaps.
REQ-025 In cut-through, if the next word is not yet buffered, TxValid SHALL drop until it is, and then resume.
REQ-026 After the final data byte, the FSM goes to PAD (macro on, frame <60 bytes) or to IDLE.
REQ-027 Back-to-back frames SHALL have at most 2 idle cycles between TxLast of one frame and the first byte of the next.
REQ-028 Read and write pointers SHALL be $clog2(DEPTH_WORDS)+1 bits wrapping modulo 2*DEPTH_WORDS; full and empty SHALL be decided by the MSB plus equal lower bits.
REQ-029 A simultaneous read and write when full or empty SHALL be handled correctly (write blocked when full, read blocked when empty).

Reset
REQ-030 On resetn low, the block SHALL asynchronously clear the pointers, FramesStored and Overflow, and enter IDLE.
REQ-031 During reset, outputs SHALL be TxValid=0, TxLast=0, TxData=0 and RvviAxiWready=0; Wready SHALL go to 1 on the first edge after release.
REQ-032 A reset mid-frame SHALL discard all buffered data; no partial frame is emitted after release.

Configuration
REQ-033 Macro RVVI_TX_MIN_FRAME_PAD_EN: when defined, frames shorter than 60 bytes SHALL be extended with 8'h00 bytes in PAD, with TxLast on byte 60; frames of 60 bytes or more are unchanged.
REQ-034 When RVVI_TX_MIN_FRAME_PAD_EN is undefined, PAD SHALL not exist and TxLast SHALL mark the last data byte.

Verification
REQ-035 Scenario 1: one frame of 16 words, all Wstrb=F, TxReady=1 -> 64 consecutive bytes, TxLast on byte 64, first TxValid 3 cycles after the last word is accepted.
REQ-036 Scenario 2: a 3-word frame with last Wstrb=4'h3 -> 10 bytes; with the macro, 60 bytes, bytes 11-60 = 00, and TxLast on byte 60.
REQ-037 Scenario 3: TxReady held 0 while 2 frames are written -> FramesStored=2, TxData stable; TxReady=1 -> both frames sent and FramesStored=0.
REQ-038 Scenario 4: a 600-word frame with DEPTH_WORDS=512 -> Wready low at 512 words, Overflow=1, cut-through starts, all 2400 bytes sent in order.
REQ-039 Scenario 5: a last word accepted in the same cycle as the prior frame's TxLast handshake -> FramesStored unchanged at 1.
REQ-040 Scenario 6: resetn pulsed low mid-frame -> TxValid=0 immediately, FramesStored=0, and no stale bytes after release.
